// File: rtl/btn_scan_arbiter.sv
// Button front end: tick generator, 2-flop synchronizer, per-button debounce,
// press-event pending vector and round-robin valid/ready event arbiter.
module btn_scan_arbiter #(
  parameter int N_BTN    = 4,
  parameter int TICK_DIV = 250000,
  parameter int DEB_CNT  = 4,
  parameter int ID_W     = $clog2(N_BTN)
) (
  input  logic             kartclk,
  input  logic             rstn,
  input  logic [N_BTN-1:0] btn,
  output logic             tick,
  output logic [N_BTN-1:0] held,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  input  logic             evt_ready,
  output logic             overrun
);

  localparam int TCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TCNT_W-1:0] tick_cnt;
  logic [N_BTN-1:0]  sync1, bsync;
  logic [N_BTN-1:0]  held_d;
  logic [N_BTN-1:0]  rise;
  logic [3:0]        deb_cnt [N_BTN];
  logic [N_BTN-1:0]  pending;
  logic [N_BTN-1:0]  grant_mask;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_id;
  logic              found;
  logic              advance;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_BTN) s = s - N_BTN;
    return ID_W'(s);
  endfunction

  assign tick = (tick_cnt == TCNT_W'(TICK_DIV - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge kartclk or negedge rstn) begin
    if (!rstn) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TCNT_W'(1);
    end
  end

  always_ff @(posedge kartclk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= '0;
      bsync <= '0;
    end else begin
      sync1 <= btn;
      bsync <= sync1;
    end
  end

  // A new level is accepted on the DEB_CNT-th consecutive tick that disagrees with held.
  // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any other state.
  always_ff @(posedge kartclk or negedge rstn) begin
    if (!rstn) begin
      held <= '0;
      for (int i = 0; i < N_BTN; i++) deb_cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (bsync[i] == held[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == 4'(DEB_CNT - 1)) begin
          held[i]    <= ~held[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge kartclk or negedge rstn) begin
    if (!rstn) held_d <= '0;
    else       held_d <= held;
  end

  assign rise    = held & ~held_d;
  assign advance = ~evt_valid | evt_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    found      = 1'b0;
    grant_id   = '0;
    grant_mask = '0;
    for (int j = 0; j < N_BTN; j++) begin
      if (!found && pending[wrap_idx(rr_ptr, j)]) begin
        found    = 1'b1;
        grant_id = wrap_idx(rr_ptr, j);
      end
    end
    if (advance && found) grant_mask[grant_id] = 1'b1;
  end

  // A rise that lands on an already pending button is dropped, unless that bit is granted now.
  always_ff @(posedge kartclk or negedge rstn) begin
    if (!rstn) begin
      pending   <= '0;
      overrun   <= 1'b0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      pending <= (pending & ~grant_mask) | rise;
      if (|(rise & pending & ~grant_mask)) overrun <= 1'b1;
      if (advance) begin
        evt_valid <= found;
        if (found) begin
          evt_id <= grant_id;
          rr_ptr <= wrap_idx(grant_id, 1);
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_scan_arbiter.sv
// Self-checking bench for btn_scan_arbiter: scoreboard queue of expected event ids,
// popped by a negedge monitor on every completed handshake.
module tb_btn_scan_arbiter;

  localparam int N_BTN    = 4;
  localparam int TICK_DIV = 10;
  localparam int DEB_CNT  = 3;
  localparam int ID_W     = 2;

  logic             kartclk = 1'b0;
  logic             rstn;
  logic [N_BTN-1:0] btn;
  logic             tick;
  logic [N_BTN-1:0] held;
  logic             evt_valid;
  logic [ID_W-1:0]  evt_id;
  logic             evt_ready;
  logic             overrun;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n_hs   = 0;
  int exp_q[$];
  int hs_cyc[$];

  always #5 kartclk = ~kartclk;

  btn_scan_arbiter #(
    .N_BTN(N_BTN), .TICK_DIV(TICK_DIV), .DEB_CNT(DEB_CNT), .ID_W(ID_W)
  ) dut (
    .kartclk(kartclk), .rstn(rstn), .btn(btn), .tick(tick), .held(held),
    .evt_valid(evt_valid), .evt_id(evt_id), .evt_ready(evt_ready), .overrun(overrun)
  );

  task automatic step();
    @(posedge kartclk);
    #1;
  endtask

  task automatic wait_held(input int i, input logic v, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (held[i] === v) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic monitor();
    logic            stall_prev = 1'b0;
    logic [ID_W-1:0] id_prev = '0;
    int              exp_id;
    forever begin
      @(negedge kartclk);
      cyc++;
      if (rstn !== 1'b1) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          checks++;
          if (evt_id !== id_prev) begin
            errors++;
            $display("FAIL id_stable: evt_id=%0d while stalled, required %0d", evt_id, id_prev);
          end
        end
        if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
          n_hs++;
          hs_cyc.push_back(cyc);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: evt_id=%0d, required no event", evt_id);
          end else begin
            exp_id = exp_q.pop_front();
            if (evt_id !== ID_W'(exp_id)) begin
              errors++;
              $display("FAIL event_id: got %0d, required %0d", evt_id, exp_id);
            end
          end
        end
        stall_prev = (evt_valid === 1'b1) && (evt_ready === 1'b0);
        id_prev    = evt_id;
      end
    end
  endtask

  task automatic test_reset();
    logic exp_tick;
    rstn = 1'b0; btn = '0; evt_ready = 1'b0;
    #12;
    checks += 5;
    if (tick !== 1'b0)      begin errors++; $display("FAIL reset_tick: got %b, required 0", tick); end
    if (held !== '0)        begin errors++; $display("FAIL reset_held: got %b, required 0000", held); end
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", evt_valid); end
    if (evt_id !== '0)      begin errors++; $display("FAIL reset_id: got %0d, required 0", evt_id); end
    if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
    step();
    rstn = 1'b1;
    for (int k = 0; k < 30; k++) begin
      exp_tick = (k % TICK_DIV) == TICK_DIV - 1;
      checks++;
      if (tick !== exp_tick) begin
        errors++;
        $display("FAIL tick_cycle%0d: got %b, required %b", k, tick, exp_tick);
      end
      step();
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    int pair_a [2] = '{0, 1};
    int pair_b [2] = '{2, 3};
    int first  [2] = '{0, 3};
    int second [2] = '{2, 1};
    evt_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      hs_cyc.delete();
      exp_q.push_back(first[p]);
      exp_q.push_back(second[p]);
      btn[pair_a[p]] = 1'b1;
      btn[pair_b[p]] = 1'b1;
      wait_held(pair_a[p], 1'b1, ok);
      checks += 2;
      if (!ok) begin errors++; $display("FAIL sim%0d_press: held=%b never rose", p, held); end
      if (held[pair_b[p]] !== 1'b1) begin
        errors++; $display("FAIL sim%0d_same_tick: held=%b, both bits required", p, held);
      end
      for (int c = 0; c < 6; c++) step();
      checks += 2;
      if (hs_cyc.size() != 2) begin
        errors++; $display("FAIL sim%0d_count: %0d events, required 2", p, hs_cyc.size());
      end else if (hs_cyc[1] - hs_cyc[0] != 1) begin
        errors++; $display("FAIL sim%0d_back_to_back: gap %0d cycles, required 1", p, hs_cyc[1] - hs_cyc[0]);
      end
      if (exp_q.size() != 0) begin
        errors++; $display("FAIL sim%0d_drain: %0d events missing, required 0", p, exp_q.size());
        exp_q.delete();
      end
      btn = '0;
      wait_held(pair_a[p], 1'b0, ok);
      wait_held(pair_b[p], 1'b0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL sim%0d_release: held=%b, required 0000", p, held); end
    end
  endtask

  task automatic test_bounce();
    bit ok;
    int base;
    evt_ready = 1'b1;
    base = n_hs;
    for (int c = 0; c < 40; c++) begin
      if (c % 4 == 0) btn[1] = ~btn[1];
      step();
    end
    checks++;
    if (held[1] !== 1'b0) begin errors++; $display("FAIL bounce_filtered: held[1]=%b, required 0", held[1]); end
    btn[1] = 1'b1;
    exp_q.push_back(1);
    wait_held(1, 1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bounce_accept: held[1]=%b, required 1", held[1]); end
    step();
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL bounce_latency1: evt_valid=%b, required 0", evt_valid); end
    step();
    checks += 2;
    if (evt_valid !== 1'b1) begin errors++; $display("FAIL bounce_latency2: evt_valid=%b, required 1", evt_valid); end
    if (evt_id !== 2'd1)    begin errors++; $display("FAIL bounce_id: evt_id=%0d, required 1", evt_id); end
    for (int c = 0; c < 4; c++) step();
    btn[1] = 1'b0;
    wait_held(1, 1'b0, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL bounce_release: held[1]=%b, required 0", held[1]); end
    if (n_hs - base != 1) begin errors++; $display("FAIL bounce_one_event: %0d events, required 1", n_hs - base); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL bounce_overrun: overrun=%b, required 0", overrun); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int base;
    evt_ready = 1'b0;
    base = n_hs;
    for (int press = 0; press < 3; press++) begin
      if (press < 2) exp_q.push_back(3);
      btn[3] = 1'b1;
      wait_held(3, 1'b1, ok);
      step();
      step();
      checks += 3;
      if (!ok) begin errors++; $display("FAIL bp%0d_press: held[3]=%b, required 1", press, held[3]); end
      if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin
        errors++; $display("FAIL bp%0d_present: valid=%b id=%0d, required valid=1 id=3", press, evt_valid, evt_id);
      end
      if (overrun !== (press == 2)) begin
        errors++; $display("FAIL bp%0d_overrun: overrun=%b, required %b", press, overrun, press == 2);
      end
      for (int c = 0; c < 8; c++) step();
      btn[3] = 1'b0;
      wait_held(3, 1'b0, ok);
    end
    evt_ready = 1'b1;
    for (int c = 0; c < 5; c++) step();
    checks += 3;
    if (n_hs - base != 2)     begin errors++; $display("FAIL bp_delivered: %0d events, required 2", n_hs - base); end
    if (exp_q.size() != 0)    begin errors++; $display("FAIL bp_drain: %0d events missing, required 0", exp_q.size()); exp_q.delete(); end
    if (evt_valid !== 1'b0)   begin errors++; $display("FAIL bp_idle: evt_valid=%b, required 0", evt_valid); end
  endtask

  task automatic test_release_only();
    bit ok;
    bit fell;
    int base;
    int n_tick;
    evt_ready = 1'b1;
    btn[2] = 1'b1;
    exp_q.push_back(2);
    wait_held(2, 1'b1, ok);
    for (int c = 0; c < 4; c++) step();
    base = n_hs;
    for (int c = 0; c < 20; c++) begin
      if (tick === 1'b1) break;
      step();
    end
    btn[2] = 1'b0;
    n_tick = 0;
    fell = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (tick === 1'b1) n_tick++;
      if (held[2] === 1'b0) begin
        fell = 1'b1;
        break;
      end
    end
    for (int c = 0; c < 10; c++) step();
    checks += 4;
    if (!fell)             begin errors++; $display("FAIL rel_fall: held[2]=%b, required 0", held[2]); end
    if (n_tick != DEB_CNT) begin errors++; $display("FAIL rel_ticks: fell after %0d ticks, required %0d", n_tick, DEB_CNT); end
    if (n_hs != base)      begin errors++; $display("FAIL rel_no_event: %0d events on release, required 0", n_hs - base); end
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL rel_idle: evt_valid=%b, required 0", evt_valid); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int base;
    evt_ready = 1'b0;
    btn[0] = 1'b1;
    btn[1] = 1'b1;
    wait_held(0, 1'b1, ok);
    step();
    step();
    checks++;
    if (evt_valid !== 1'b1) begin errors++; $display("FAIL mr_present: evt_valid=%b, required 1", evt_valid); end
    #2;
    rstn = 1'b0;
    btn  = '0;
    #1;
    checks += 5;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL mr_valid: got %b, required 0", evt_valid); end
    if (evt_id !== '0)      begin errors++; $display("FAIL mr_id: got %0d, required 0", evt_id); end
    if (held !== '0)        begin errors++; $display("FAIL mr_held: got %b, required 0000", held); end
    if (overrun !== 1'b0)   begin errors++; $display("FAIL mr_overrun: got %b, required 0", overrun); end
    if (tick !== 1'b0)      begin errors++; $display("FAIL mr_tick: got %b, required 0", tick); end
    for (int c = 0; c < 3; c++) step();
    rstn = 1'b1;
    evt_ready = 1'b1;
    base = n_hs;
    for (int c = 0; c < 50; c++) step();
    checks += 2;
    if (n_hs != base)       begin errors++; $display("FAIL mr_stale: %0d events after reset, required 0", n_hs - base); end
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL mr_idle: evt_valid=%b, required 0", evt_valid); end
  endtask

  initial begin
    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog expired");
      end
    join_none
    test_reset();
    test_simultaneous();
    test_bounce();
    test_backpressure();
    test_release_only();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_scan_arbiter.md
# btn_scan_arbiter

Button front end for the whack-a-mole game. It produces the 5 ms sampling tick on the board clock and uses it to debounce all mole buttons. Each debounced press becomes one event, and a round-robin arbiter delivers the events one at a time to the game FSM over a valid/ready handshake. It sits between the raw board buttons and the game controller, replacing free-running divided clocks with a single-clock-domain tick enable.

## Interface
- N_BTN, 4: number of buttons, legal range 2..8.
- TICK_DIV, 250000: kartclk cycles per sampling tick (5 ms at 50 MHz).
- DEB_CNT, 4: consecutive ticks a new level must persist before it is accepted, legal range 1..15.
- ID_W, $clog2(N_BTN): event id width (derived).
- kartclk  in  1  board clock; all logic on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- btn  in  N_BTN  raw asynchronous buttons, active-high.
- tick  out  1  one-cycle pulse every TICK_DIV cycles.
- held  out  N_BTN  debounced button levels.
- evt_valid  out  1  event presented.
- evt_id  out  ID_W  index of the pressed button; stable while evt_valid=1.
- evt_ready  in  1  consumer accepts the event; may depend combinationally on evt_valid.
- overrun  out  1  sticky flag: a press arrived while its button already had an event pending.

## Operation
- Reset, asynchronous on rstn=0: tick, held, evt_valid, evt_id and overrun are 0. Tick counter, synchronizers, debounce counters, pending vector and round-robin pointer rr_ptr are also 0.
- Tick generator: the counter runs 0..TICK_DIV-1 and wraps. tick=1 in the cycle where the count equals TICK_DIV-1.
- Synchronizer: btn passes through 2 flops to give bsync.
- Debounce, per button i, evaluated only on tick cycles:
  - If bsync[i]==held[i], the counter clears.
  - Otherwise the counter increments. When the increment reaches DEB_CNT, held[i] toggles and the counter clears.
- Event source: a 0→1 transition of held[i] sets pending[i]. A 1→0 transition generates no event.
- Overrun: if held[i] rises while pending[i] is already 1, overrun is set (sticky until reset) and the press is dropped. pending[i] stays 1.
- Arbiter, acting when evt_valid=0 or when the handshake completes this cycle:
  - Search pending starting at rr_ptr, ascending with wrap mod N_BTN.
  - Take the first set bit k. Register evt_valid=1 and evt_id=k, clear pending[k], and set rr_ptr=(k+1) mod N_BTN.
  - If no bit is set, evt_valid goes to 0.
- Handshake: an event is transferred on the edge where evt_valid and evt_ready are both 1. evt_id must not change while evt_valid=1 and evt_ready=0.
- Simultaneous set and clear on pending[k] (grant and a new rising edge in the same cycle): the set wins, and pending[k] stays 1 with no overrun.

## Timing
- Synchronizer latency: 2 cycles.
- Acceptance: held[i] updates on the edge that ends the DEB_CNT-th consecutive differing tick cycle.
- Event latency: pending[i] is set 1 cycle after held[i] rises, and evt_valid rises 1 cycle after that (when idle).
- Back-to-back: with evt_ready held at 1 and several bits pending, a new event is presented every cycle with evt_valid continuously high.
- First tick after reset release: cycle TICK_DIV-1, then every TICK_DIV cycles.
- rstn asserted mid-handshake: evt_valid drops immediately and all pending events are discarded.

## Test plan
Bench parameters: TICK_DIV=10, DEB_CNT=3, N_BTN=4.
- Reset: hold rstn=0, then release → all outputs 0. tick pulses at cycles 9, 19, 29 after release.
- Bounce: btn[1] toggles every 4 cycles for 40 cycles, then stays at 1 → held[1] rises only after 3 consecutive steady ticks. Exactly one event with id=1 and no overrun.
- Simultaneous presses, evt_ready=1:
  - btn[0] and btn[2] debounced on the same tick → id=0, then id=2 on consecutive cycles, leaving rr_ptr=3.
  - Then btn[1] and btn[3] pressed together → id=3, then id=1.
- Backpressure, evt_ready=0:
  - Press btn[3] → id=3 is held stable.
  - Release and press again → pending[3] is set with no overrun.
  - A third press → overrun=1.
  - Raise evt_ready → two id=3 events are delivered.
- Release only: btn[2] goes 1→0 after an accepted press → held[2] falls after 3 ticks and no event is generated.
- Mid-operation reset: pull rstn low while evt_valid=1 and another bit is pending → outputs go to 0 asynchronously. After release, no stale event appears.
